// File: rtl/nic8_sequencer_if.sv
// nic8_sequencer_if: bus between the nic8 fetch/execute sequencer and the
// datapath. The sequencer uses the master modport and the datapath uses the
// slave modport. step/stepAck exist in every build. They only carry meaning
// when NIC8_SINGLE_STEP_EN is defined.
interface nic8_sequencer_if;
  logic [7:0]  ir;
  logic        aZero;
  logic [13:0] controlBits;
  logic        incPC;
  logic [1:0]  phase;
  logic        halted;
  logic        step;
  logic        stepAck;

  modport master (
    input  ir, aZero, step,
    output controlBits, incPC, phase, halted, stepAck
  );

  modport slave (
    output ir, aZero, step,
    input  controlBits, incPC, phase, halted, stepAck
  );
endinterface

// File: rtl/nic8_sequencer.sv
// nic8_sequencer: fetch/execute control sequencer for the nic8 datapath.
// It owns the IDLE -> FETCH -> EXEC instruction cycle and decodes IR into the
// 14-bit control word {loadIR,loadPC,loadA,loadB,loadX,doOut,storeMem,
// assertM,assertE,assertA,assertX,immediate,jumpControl,doSubtract}.
// Optional feature macro: NIC8_SINGLE_STEP_EN. When it is defined, EXEC
// waits for step before the next FETCH. When it is undefined, the block
// free-runs and stepAck is tied low.
module nic8_sequencer (
  input  logic             clk,
  input  logic             reset,
  nic8_sequencer_if.master bus
);

  localparam int B_LOADIR   = 13;
  localparam int B_LOADPC   = 12;
  localparam int B_LOADA    = 11;
  localparam int B_LOADB    = 10;
  localparam int B_LOADX    = 9;
  localparam int B_DOOUT    = 8;
  localparam int B_STOREMEM = 7;
  localparam int B_ASSERTM  = 6;
  localparam int B_ASSERTE  = 5;
  localparam int B_ASSERTA  = 4;
  localparam int B_ASSERTX  = 3;
  localparam int B_IMM      = 2;
  localparam int B_JUMP     = 1;
  localparam int B_SUB      = 0;

  // S_IDLE0/S_IDLE1 give one full idle cycle after reset is released.
  // S_HOLD is the quiet part of EXEC while the block waits for step.
  typedef enum logic [2:0] {
    S_IDLE0 = 3'd0,
    S_IDLE1 = 3'd1,
    S_FETCH = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [13:0] cw_s;
  logic        inc_s;
  logic [1:0]  phase_s;
  logic        halted_s;
  logic [14:0] exec_s;
  logic        is_halt_s;
  logic        unused_s;

  // Returns {control word, incPC} for a non-halt EXEC cycle.
  function automatic logic [14:0] exec_decode(input logic [7:0] ir_v, input logic a_zero_v);
    logic [13:0] cw;
    logic [1:0]  src;
    logic        taken;
    cw    = 14'd0;
    taken = 1'b0;
    src   = ir_v[2] ? 2'b00 : ir_v[7:6];
    case (src)
      2'b00:   cw[B_ASSERTM] = 1'b1;
      2'b01:   cw[B_ASSERTE] = 1'b1;
      2'b10:   cw[B_ASSERTA] = 1'b1;
      default: cw[B_ASSERTX] = 1'b1;
    endcase
    case (ir_v[5:3])
      3'd0:    cw[B_LOADA]    = 1'b1;
      3'd1:    cw[B_LOADB]    = 1'b1;
      3'd2:    cw[B_LOADX]    = 1'b1;
      3'd3:    cw[B_DOOUT]    = 1'b1;
      3'd4:    cw[B_STOREMEM] = 1'b1;
      3'd5:    cw[B_LOADPC]   = 1'b1;
      3'd6: begin
        cw[B_JUMP]   = 1'b1;
        cw[B_LOADPC] = a_zero_v;
        taken        = a_zero_v;
      end
      default: cw = 14'd0;
    endcase
    cw[B_IMM] = ir_v[2];
    cw[B_SUB] = ir_v[1];
    return {cw, ir_v[2] & ~taken};
  endfunction

  assign exec_s    = exec_decode(bus.ir, bus.aZero);
  assign is_halt_s = (bus.ir[5:3] == 3'b111);

`ifdef NIC8_SINGLE_STEP_EN
  logic step_ack_r;
  logic step_ack_nxt_s;
  assign unused_s = bus.ir[0];
`else
  assign unused_s = bus.ir[0] ^ bus.step;
`endif

  // Next-state logic and combinational control outputs from the state and ir.
  always_comb begin
    state_nxt_s = state_r;
    cw_s        = 14'd0;
    inc_s       = 1'b0;
    phase_s     = 2'd0;
    halted_s    = 1'b0;
`ifdef NIC8_SINGLE_STEP_EN
    step_ack_nxt_s = 1'b0;
`endif
    case (state_r)
      S_IDLE0: state_nxt_s = S_IDLE1;
      S_IDLE1: state_nxt_s = S_FETCH;
      S_FETCH: begin
        phase_s            = 2'd1;
        cw_s[B_LOADIR]     = 1'b1;
        cw_s[B_ASSERTM]    = 1'b1;
        inc_s              = 1'b1;
        state_nxt_s        = S_EXEC;
      end
      S_EXEC: begin
        phase_s = 2'd2;
        if (is_halt_s) begin
          state_nxt_s = S_HALT;
        end else begin
          cw_s  = exec_s[14:1];
          inc_s = exec_s[0];
`ifdef NIC8_SINGLE_STEP_EN
          if (bus.step) begin
            state_nxt_s    = S_FETCH;
            step_ack_nxt_s = 1'b1;
          end else begin
            state_nxt_s = S_HOLD;
          end
`else
          state_nxt_s = S_FETCH;
`endif
        end
      end
      S_HOLD: begin
        phase_s = 2'd2;
`ifdef NIC8_SINGLE_STEP_EN
        if (bus.step) begin
          state_nxt_s    = S_FETCH;
          step_ack_nxt_s = 1'b1;
        end else begin
          state_nxt_s = S_HOLD;
        end
`else
        state_nxt_s = S_FETCH;
`endif
      end
      S_HALT: begin
        phase_s     = 2'd3;
        halted_s    = 1'b1;
        state_nxt_s = S_HALT;
      end
      default: state_nxt_s = S_IDLE0;
    endcase
  end

  // State register. Reset returns to IDLE at once, so enables drop before the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE0;
    end else begin
      state_r <= state_nxt_s;
    end
  end

`ifdef NIC8_SINGLE_STEP_EN
  // The stepAck pulse is registered and appears in the FETCH that follows an acknowledged EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_ack_r <= 1'b0;
    end else begin
      step_ack_r <= step_ack_nxt_s;
    end
  end
  assign bus.stepAck = step_ack_r;
`else
  assign bus.stepAck = 1'b0;
`endif

  assign bus.controlBits = cw_s;
  assign bus.incPC       = inc_s;
  assign bus.phase       = phase_s;
  assign bus.halted      = halted_s;

endmodule

// File: tb/tb_nic8_sequencer.sv
// tb_nic8_sequencer: self-checking bench for nic8_sequencer. It uses a table of
// decode vectors, hand-written reset/halt/single-step sequences, and a
// randomized run checked against a spec-level reference model.
module tb_nic8_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nic8_sequencer_if bus();
  nic8_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;
  localparam logic [13:0] CW_FETCH = 14'b10000001000000;

  typedef struct {
    logic [7:0]  ir;
    logic        az;
    logic [13:0] cw;
    logic        inc;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the control word built from the decode rules, one named bit position at a time.
  function automatic logic [13:0] model_cw(input logic [7:0] i, input logic az);
    int cw;
    int src;
    int dst;
    cw  = 0;
    dst = int'(i[5:3]);
    src = i[2] ? 0 : int'(i[7:6]);
    if (dst == 7) return 14'd0;
    cw += 1 << (6 - src);
    if (dst <= 4) cw += 1 << (11 - dst);
    else if (dst == 5) cw += 1 << 12;
    else begin
      cw += 1 << 1;
      if (az) cw += 1 << 12;
    end
    if (i[2]) cw += 1 << 2;
    if (i[1]) cw += 1;
    return cw[13:0];
  endfunction

  function automatic logic model_inc(input logic [7:0] i, input logic az);
    return (i[5:3] != 3'd7) && i[2] && !((i[5:3] == 3'd6) && az);
  endfunction

  // Asserts reset in the middle of a cycle and checks that all outputs clear at once.
  // It then releases reset and returns 1 time unit into the first FETCH.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_phase", bus.phase, 0);
    chk("rst_cw", bus.controlBits, 0);
    chk("rst_inc", bus.incPC, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_ack", bus.stepAck, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_phase", bus.phase, 0);
    chk("idle_cw", bus.controlBits, 0);
    @(posedge clk); #1;
    chk("fetch_phase", bus.phase, 1);
    chk("fetch_cw", bus.controlBits, CW_FETCH);
    chk("fetch_inc", bus.incPC, 1);
  endtask

  initial begin
    logic [7:0] r_ir;
    logic       r_az;
    int         k;
    int         hl;
    logic       exp_ack;

    vecs[0] = '{8'b00_000_100, 1'b0, 14'b00100001000100, 1'b1};
    vecs[1] = '{8'b01_001_010, 1'b0, 14'b00010000100001, 1'b0};
    vecs[2] = '{8'b10_110_000, 1'b1, 14'b01000000010010, 1'b0};
    vecs[3] = '{8'b10_110_000, 1'b0, 14'b00000000010010, 1'b0};
    vecs[4] = '{8'b11_010_000, 1'b0, 14'b00001000001000, 1'b0};
    vecs[5] = '{8'b11_011_101, 1'b1, 14'b00000101000100, 1'b1};
    vecs[6] = '{8'b00_100_000, 1'b0, 14'b00000011000000, 1'b0};
    vecs[7] = '{8'b10_101_010, 1'b1, 14'b01000000010001, 1'b0};
    vecs[8] = '{8'b01_110_100, 1'b1, 14'b01000001000110, 1'b0};
    vecs[9] = '{8'b01_110_100, 1'b0, 14'b00000001000110, 1'b1};

    bus.ir = 8'h00;
    bus.aZero = 1'b0;
`ifdef NIC8_SINGLE_STEP_EN
    bus.step = 1'b1;
`else
    bus.step = 1'b0;
`endif
    #12;
    chk("por_phase", bus.phase, 0);
    do_reset();

    // Table of decode vectors: each one is a FETCH followed by an EXEC.
    for (int v = 0; v < 10; v++) begin
      bus.ir = vecs[v].ir;
      bus.aZero = vecs[v].az;
      #1 chk("tbl_fetch_cw", bus.controlBits, CW_FETCH);
      @(posedge clk); #1;
      chk("tbl_exec_phase", bus.phase, 2);
      chk("tbl_exec_cw", bus.controlBits, vecs[v].cw);
      chk("tbl_exec_inc", bus.incPC, vecs[v].inc);
      @(posedge clk); #1;
    end

    // A reset in EXEC aborts the instruction, and do_reset checks that enables drop at once.
    bus.ir = 8'b00_000_100;
    @(posedge clk); #1;
    chk("pre_abort_phase", bus.phase, 2);
    do_reset();

    // The halt instruction sticks until reset, with all enables low.
    bus.ir = 8'b00_111_000;
    @(posedge clk); #1;
    chk("halt_exec_phase", bus.phase, 2);
    chk("halt_exec_halted", bus.halted, 0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      bus.ir = 8'($urandom);
      bus.aZero = 1'($urandom);
      #1;
      chk("halt_phase", bus.phase, 3);
      chk("halt_halted", bus.halted, 1);
      chk("halt_cw", bus.controlBits, 0);
      chk("halt_inc", bus.incPC, 0);
    end
    do_reset();

`ifdef NIC8_SINGLE_STEP_EN
    // Single step: EXEC fires once, then holds quiet until a one-cycle step pulse.
    bus.step = 1'b0;
    bus.ir = 8'b00_000_100;
    bus.aZero = 1'b0;
    @(posedge clk); #1;
    chk("ss_exec_cw", bus.controlBits, 14'b00100001000100);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("ss_hold_phase", bus.phase, 2);
      chk("ss_hold_cw", bus.controlBits, 0);
      chk("ss_hold_inc", bus.incPC, 0);
      chk("ss_hold_ack", bus.stepAck, 0);
    end
    bus.step = 1'b1;
    #1 chk("ss_step_cw", bus.controlBits, 0);
    @(posedge clk); #1;
    bus.step = 1'b0;
    chk("ss_fetch_phase", bus.phase, 1);
    chk("ss_ack", bus.stepAck, 1);
    chk("ss_fetch_cw", bus.controlBits, CW_FETCH);
    bus.ir = 8'b00_111_000;
    @(posedge clk); #1;
    chk("ss_ack_end", bus.stepAck, 0);
    chk("ss_exec2_phase", bus.phase, 2);
    @(posedge clk); #1;
    chk("ss_halt_nostep", bus.phase, 3);
    bus.step = 1'b1;
    do_reset();
`endif

    // Randomized run against the reference model.
    // k counts cycles since the first FETCH, so even k is FETCH and odd k is EXEC.
    k = 0;
    hl = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      r_ir = 8'($urandom);
      if (r_ir[5:3] == 3'd7 && $urandom_range(0, 7) != 0) r_ir[5:3] = 3'($urandom_range(0, 6));
      r_az = 1'($urandom);
      bus.ir = r_ir;
      bus.aZero = r_az;
`ifndef NIC8_SINGLE_STEP_EN
      bus.step = 1'($urandom);
      exp_ack = 1'b0;
`else
      exp_ack = (hl == 0) && (k % 2 == 0) && (k > 0);
`endif
      #1;
      chk("rnd_ack", bus.stepAck, exp_ack);
      if (hl > 0) begin
        chk("rnd_halt_phase", bus.phase, 3);
        chk("rnd_halted", bus.halted, 1);
        chk("rnd_halt_cw", bus.controlBits, 0);
      end else if (k % 2 == 0) begin
        chk("rnd_fetch_phase", bus.phase, 1);
        chk("rnd_fetch_cw", bus.controlBits, CW_FETCH);
        chk("rnd_fetch_inc", bus.incPC, 1);
      end else begin
        chk("rnd_exec_phase", bus.phase, 2);
        chk("rnd_exec_halted", bus.halted, 0);
        if (r_ir[5:3] != 3'd7) begin
          chk("rnd_exec_cw", bus.controlBits, model_cw(r_ir, r_az));
          chk("rnd_exec_inc", bus.incPC, model_inc(r_ir, r_az));
        end
      end
      if (hl > 0) hl++;
      else if (k % 2 == 1 && r_ir[5:3] == 3'd7) hl = 1;
      k++;
      if (hl > 4) begin
        do_reset();
        k = 0;
        hl = 0;
      end else begin
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nic8_sequencer.md
# nic8_sequencer

Fetch/execute control sequencer for the nic8 8-bit datapath. It owns the instruction cycle: it fetches into IR, decodes IR, and drives the 14-bit control word that the register file, ALU, memory and output port consume. It also handles halt and an optional single-step handshake. It sits between the datapath registers (IR, A flag) and every load/assert/store enable in the CPU.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- ir  input  8  instruction register contents (from datapath).
- aZero  input  1  high when A register == 8'h00.
- controlBits  output  14  {loadIR,loadPC,loadA,loadB,loadX,doOut,storeMem,assertM,assertE,assertA,assertX,immediate,jumpControl,doSubtract}, MSB first.
- incPC  output  1  datapath increments PC at the next posedge.
- phase  output  2  current state: 0 IDLE, 1 FETCH, 2 EXEC, 3 HALT.
- halted  output  1  high in HALT.
- step  input  1  single-step request (only with NIC8_SINGLE_STEP_EN).
- stepAck  output  1  one-cycle pulse per completed instruction (only with NIC8_SINGLE_STEP_EN).

## Operation
- States: IDLE -> FETCH -> EXEC -> FETCH ...; EXEC(halt) -> HALT; HALT is left only by reset.
- IDLE: all outputs 0. The block stays here for exactly one cycle after reset deasserts.
- FETCH: controlBits = loadIR|assertM; incPC = 1. IR is valid in the following EXEC.
- EXEC decode:
  - ir[7:6] selects the bus source: 00 assertM, 01 assertE, 10 assertA, 11 assertX.
  - ir[5:3] selects the destination: 000 loadA, 001 loadB, 010 loadX, 011 doOut, 100 storeMem, 101 loadPC (unconditional), 110 jumpControl plus loadPC only if aZero, 111 halt (no load, no source asserted).
  - ir[2] = immediate: the memory operand is at PC. When set, assertM is forced regardless of ir[7:6], and incPC = 1 in EXEC. A taken jump suppresses incPC.
  - ir[1] = doSubtract, passed through in EXEC only. ir[0] is ignored.
- Exactly one assert* bit is high in FETCH and in non-halt EXEC. All assert* bits are 0 in IDLE and HALT.
- storeMem with source assertM: legal encoding, still executed (memory is self-copied); no special case.

## Timing
- State is registered. controlBits, incPC and phase are combinational from the state register and ir. They have no dependence on step within a cycle.
- Each instruction takes 2 cycles (FETCH + EXEC), which is 1 instruction per 2 clocks free-running.
- Reset: async. controlBits, incPC, stepAck and halted are all 0 and phase = 0 within the same delta as reset rising. The first FETCH is on the 2nd posedge after reset falls.
- Reset during EXEC aborts it: no load fires, because enables drop before the posedge.
- A halt instruction: halted = 1 from the posedge that ends its EXEC. It stays high until reset.

## Configuration
- NIC8_SINGLE_STEP_EN defined:
  - FETCH→EXEC is unconditional. EXEC→FETCH advances only on a cycle where step = 1; otherwise the block holds in EXEC with all enables 0 after the first EXEC cycle, so the instruction executes once.
  - stepAck pulses 1 cycle on the EXEC→FETCH transition. step held high means free-run.
  - The halt instruction goes to HALT without waiting for step.
- Undefined: step is ignored and stepAck is tied 0. The block free-runs.

## Test plan
- Reset pulse mid-run, then release -> phase 0 for 1 cycle, FETCH (controlBits = 14'b10000001000000, incPC = 1) on the 2nd posedge.
- ir = 8'b00_000_100 (immediate load A) -> EXEC controlBits = loadA|assertM|immediate, incPC = 1.
- ir = 8'b01_001_010 (B <= ALU subtract) -> loadB|assertE|doSubtract, incPC = 0.
- ir = 8'b10_110_000 with aZero = 1 -> loadPC|assertA|jumpControl, incPC = 0. Same with aZero = 0 -> jumpControl|assertA only.
- ir = 8'b00_111_000 -> halted = 1 after EXEC; phase stays 3 for 20 cycles; controlBits = 0.
- NIC8_SINGLE_STEP_EN, step = 0 for 5 cycles then a 1-cycle pulse -> EXEC enables live for 1 cycle only; a single stepAck pulse; next FETCH follows.
